ram_read_scanner: RTL

Read-side sequencer for the 32x4 display RAM. Drives the RAM read address from a clock-enable prescaler on the 50 MHz clock, so no derived clock is needed. Aligns the RAM output with the address that produced it and presents a coherent address/data pair to the seg7 display stage. Supports free-run scanning and single-step scanning, and refreshes the displayed data live while paused.

---
 rtl/ram_read_scanner.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ram_read_scanner.sv
// ---------------------------------------------------------------------------
// ram_read_scanner
//
// Read-side sequencer for the 32x4 display RAM. A clock-enable prescaler on
// the system clock advances the RAM read address, so no derived clock is
// needed. A small in-flight counter waits out the RAM read latency, so the
// address/data pair handed to the seg7 stage always belongs together.
// Scanning is either free-running (run=1, one step every TICK_DIV cycles) or
// single-step (run=0, one step per rising edge of step). Whenever no read is
// in flight, disp_data re-samples q every cycle. A RAM write to the displayed
// address therefore shows up without advancing.
//
// Optional build macro: SCAN_BCD_EN
//   When defined, adds disp_tens/disp_ones (decimal digits of disp_addr).
//   This option needs ADDR_W <= 6.
//
// Ports:
//   clock       in   1       system clock
//   reset       in   1       synchronous, active-high reset
//   run         in   1       1 = auto-advance every TICK_DIV cycles, 0 = step
//   step        in   1       level; each rising edge advances when run=0
//   q           in   DATA_W  RAM read data
//   rdaddress   out  ADDR_W  RAM read address
//   disp_addr   out  ADDR_W  address currently displayed
//   disp_data   out  DATA_W  data at disp_addr
//   disp_valid  out  1       disp_addr/disp_data coherent and valid
//   wrap        out  1       one-cycle pulse when rdaddress wraps to 0
//   disp_tens   out  4       disp_addr / 10   (SCAN_BCD_EN only)
//   disp_ones   out  4       disp_addr % 10   (SCAN_BCD_EN only)
// ---------------------------------------------------------------------------
module ram_read_scanner #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter int TICK_DIV = 25000000,
  parameter int RD_LAT   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] rdaddress,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              wrap
`ifdef SCAN_BCD_EN
  ,
  output logic [3:0]        disp_tens,
  output logic [3:0]        disp_ones
`endif
);

  // Prescaler width is sized to hold TICK_DIV-1.
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 2;
  localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 1);
  localparam logic [1:0]    FLIGHT_INIT = 2'(RD_LAT);

  // State registers
  logic [PW-1:0]     presc_q,     presc_d;
  logic              step_q;
  logic [1:0]        flight_q,    flight_d;
  logic [ADDR_W-1:0] rdaddr_q,    rdaddr_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_vld_q,  disp_vld_d;
  logic              wrap_q,      wrap_d;

  // Combinational control
  logic tick_s;
  logic step_rise_s;
  logic advance_s;
  logic capture_s;

`ifdef SCAN_BCD_EN
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  // Decimal tens digit of a scan address (address is below 64).
  function automatic logic [3:0] bcd_tens(input logic [ADDR_W-1:0] a);
    logic [6:0] w;
    w = 7'(a);
    return 4'(w / 7'd10);
  endfunction

  // Decimal ones digit of a scan address (address is below 64).
  function automatic logic [3:0] bcd_ones(input logic [ADDR_W-1:0] a);
    logic [6:0] w;
    w = 7'(a);
    return 4'(w % 7'd10);
  endfunction
`endif

  // Next-state logic: prescaler, step edge, advance, flight and capture
  always_comb begin
    tick_s      = run & (presc_q == TICK_LAST);
    step_rise_s = step & ~step_q;
    // While running, step edges are deliberately ignored.
    advance_s   = (run & tick_s) | (~run & step_rise_s);
    // Capture only once the read for the current address has landed.
    capture_s   = ~advance_s & (flight_q == 2'd0);

    if (!run) begin
      presc_d = {PW{1'b0}};
    end else if (tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (advance_s) begin
      rdaddr_d = rdaddr_q + ADDR_W'(1);
      wrap_d   = (rdaddr_q == {ADDR_W{1'b1}});
      // Restarting the flight drops any pair still in the pipeline.
      flight_d = FLIGHT_INIT;
    end else begin
      rdaddr_d = rdaddr_q;
      wrap_d   = 1'b0;
      if (flight_q != 2'd0) begin
        flight_d = flight_q - 2'd1;
      end else begin
        flight_d = flight_q;
      end
    end

    if (capture_s) begin
      disp_addr_d = rdaddr_q;
      disp_data_d = q;
      disp_vld_d  = 1'b1;
    end else begin
      disp_addr_d = disp_addr_q;
      disp_data_d = disp_data_q;
      disp_vld_d  = disp_vld_q;
    end

`ifdef SCAN_BCD_EN
    if (capture_s) begin
      tens_d = bcd_tens(rdaddr_q);
      ones_d = bcd_ones(rdaddr_q);
    end else begin
      tens_d = tens_q;
      ones_d = ones_q;
    end
`endif
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q     <= {PW{1'b0}};
      step_q      <= 1'b0;
      flight_q    <= FLIGHT_INIT;
      rdaddr_q    <= {ADDR_W{1'b0}};
      disp_addr_q <= {ADDR_W{1'b0}};
      disp_data_q <= {DATA_W{1'b0}};
      disp_vld_q  <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      step_q      <= step;
      flight_q    <= flight_d;
      rdaddr_q    <= rdaddr_d;
      disp_addr_q <= disp_addr_d;
      disp_data_q <= disp_data_d;
      disp_vld_q  <= disp_vld_d;
      wrap_q      <= wrap_d;
    end
  end

`ifdef SCAN_BCD_EN
  // Decimal digit registers, updated on the same edge as disp_addr
  always_ff @(posedge clock) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign disp_tens = tens_q;
  assign disp_ones = ones_q;
`endif

  assign rdaddress  = rdaddr_q;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_vld_q;
  assign wrap       = wrap_q;

endmodule
